// File: rtl/mc_pkg.sv
// Shared constants and state type for the multi-cycle MIPS controller.
// Opcode/funct encodings, ALU control codes and the FSM state enum.
package mc_pkg;

    localparam int ALU_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [ALU_W-1:0] ALU_ADD = 5'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 5'd1;
    localparam logic [ALU_W-1:0] ALU_AND = 5'd2;
    localparam logic [ALU_W-1:0] ALU_OR  = 5'd3;
    localparam logic [ALU_W-1:0] ALU_SLT = 5'd4;
    localparam logic [ALU_W-1:0] ALU_SLL = 5'd5;
    localparam logic [ALU_W-1:0] ALU_SRL = 5'd6;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_RTYPE,
        S_RTYPE_WB,
        S_MEMADR,
        S_MEMRD,
        S_MEM_WB,
        S_MEMWR,
        S_ADDI_EX,
        S_ADDI_WB,
        S_BRANCH,
        S_JUMP,
        S_ILLEGAL
    } state_t;

    function automatic logic is_shift(input logic [5:0] fn);
        return (fn == FN_SLL) || (fn == FN_SRL);
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type funct to ALU control decoder with a funct-valid flag.
// Shared by the RTYPE execute step and the illegal-instruction check.
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic [5:0]       funct,
    output logic [ALU_W-1:0] alu_op,
    output logic             funct_ok
);

    always_comb begin
        alu_op   = ALU_ADD;
        funct_ok = 1'b1;
        unique case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            FN_SLL:  alu_op = ALU_SLL;
            FN_SRL:  alu_op = ALU_SRL;
            default: funct_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM for a shared-memory datapath.
// Define MULTICYCLE_PERF_EN to add cycle_count/instr_count outputs.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int ALUC_W        = 5,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic [1:0]        pc_src,
    output logic              iord,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic              reg_write,
    output logic [1:0]        alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [ALUC_W-1:0] alu_ctrl,
    output logic              illegal,
    output logic              instr_done
`ifdef MULTICYCLE_PERF_EN
    ,
    output logic [31:0]       cycle_count,
    output logic [31:0]       instr_count
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic [ALU_W-1:0] alu_op;
    logic [ALU_W-1:0] alu_sel;
    logic             funct_ok;
    logic             mem_ok;

    assign mem_ok = MEM_HANDSHAKE ? mem_ready : 1'b1;

    mc_alu_decoder u_alu_dec (
        .funct    (funct),
        .alu_op   (alu_op),
        .funct_ok (funct_ok)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:   if (mem_ok) state_d = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_RTYPE:     state_d = S_RTYPE;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_BEQ,
                    OP_BNE:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_RTYPE:   state_d = funct_ok ? S_RTYPE_WB : S_ILLEGAL;
            S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ok) state_d = S_MEM_WB;
            S_MEMWR:   if (mem_ok) state_d = S_FETCH;
            S_ADDI_EX: state_d = S_ADDI_WB;
            default:   state_d = S_FETCH;
        endcase
        if (rst) state_d = S_FETCH;
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        alu_sel    = ALU_ADD;
        illegal    = 1'b0;
        instr_done = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ok;
                pc_write  = mem_ok;
            end
            S_DECODE:  alu_src_b = 2'd3;
            S_RTYPE: begin
                alu_src_a = is_shift(funct) ? 2'd2 : 2'd1;
                alu_sel   = alu_op;
            end
            S_RTYPE_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMADR, S_ADDI_EX: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ok;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 2'd1;
                alu_sel    = ALU_SUB;
                pc_src     = 2'd1;
                pc_write   = (opcode == OP_BEQ) ? zero : ~zero;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = 2'd2;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            S_ILLEGAL: illegal = 1'b1;
            default: ;
        endcase
        // Reset suppresses every side effect of the current state at once.
        if (rst) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            illegal    = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign alu_ctrl = ALUC_W'(alu_sel);

`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cycle_count_q;
    logic [31:0] cycle_count_d;
    logic [31:0] instr_count_q;
    logic [31:0] instr_count_d;

    always_comb begin
        cycle_count_d = cycle_count_q + 32'd1;
        instr_count_d = instr_count_q + {31'd0, instr_done};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count_q <= 32'd0;
            instr_count_q <= 32'd0;
        end else begin
            cycle_count_q <= cycle_count_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller.
// Expected outputs come from a per-instruction step list built from the ISA rules.
module tb_multicycle_controller;

    localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011;
    localparam logic [5:0] O_SW = 6'b101011, O_ADDI = 6'b001000;
    localparam logic [5:0] O_BEQ = 6'b000100, O_BNE = 6'b000101;
    localparam logic [5:0] O_J = 6'b000010;

    typedef enum {P_F, P_D, P_RT, P_RTWB, P_MA, P_MR, P_MWB,
                  P_MW, P_AE, P_AW, P_BR, P_J, P_ILL} ph_t;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic [1:0] a;
        logic [1:0] b;
        logic [4:0] alu;
        logic       illegal;
        logic       done;
    } ov_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, illegal, instr_done;
    logic [1:0] pc_src, alu_src_a, alu_src_b;
    logic [4:0] alu_ctrl;
`ifdef MULTICYCLE_PERF_EN
    logic [31:0] cycle_count, instr_count;
`endif

    int checks = 0;
    int errors = 0;

    ph_t ph_q[$];
    ov_t obs_q[$];
    ov_t exp_q[$];
    ov_t msk_q[$];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .illegal    (illegal),
        .instr_done (instr_done)
`ifdef MULTICYCLE_PERF_EN
        ,
        .cycle_count(cycle_count),
        .instr_count(instr_count)
`endif
    );

    // ALU operation each R-type funct should select; ok=0 for unknown funct.
    function automatic logic [4:0] ref_alu(input logic [5:0] fn,
                                           output logic ok);
        ok = 1'b1;
        case (fn)
            6'b100000: return 5'd0;
            6'b100010: return 5'd1;
            6'b100100: return 5'd2;
            6'b100101: return 5'd3;
            6'b101010: return 5'd4;
            6'b000000: return 5'd5;
            6'b000010: return 5'd6;
            default: begin
                ok = 1'b0;
                return 5'd0;
            end
        endcase
    endfunction

    task automatic build_phases(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        logic [4:0] unused_alu;
        unused_alu = ref_alu(fn, ok);
        ph_q.delete();
        ph_q.push_back(P_F);
        ph_q.push_back(P_D);
        case (op)
            O_R: begin
                ph_q.push_back(P_RT);
                ph_q.push_back(ok ? P_RTWB : P_ILL);
            end
            O_LW: begin
                ph_q.push_back(P_MA);
                ph_q.push_back(P_MR);
                ph_q.push_back(P_MWB);
            end
            O_SW: begin
                ph_q.push_back(P_MA);
                ph_q.push_back(P_MW);
            end
            O_ADDI: begin
                ph_q.push_back(P_AE);
                ph_q.push_back(P_AW);
            end
            O_BEQ, O_BNE: ph_q.push_back(P_BR);
            O_J: ph_q.push_back(P_J);
            default: ph_q.push_back(P_ILL);
        endcase
    endtask

    function automatic ov_t exp_vec(input ph_t ph, input logic [5:0] op,
                                    input logic [5:0] fn, input logic mr,
                                    input logic z);
        ov_t e;
        logic ok;
        e = '0;
        case (ph)
            P_F: begin
                e.mem_read = 1'b1;
                e.b = 2'd1;
                e.ir_write = mr;
                e.pc_write = mr;
            end
            P_D: e.b = 2'd3;
            P_RT: begin
                e.a = (fn == 6'b000000 || fn == 6'b000010) ? 2'd2 : 2'd1;
                e.alu = ref_alu(fn, ok);
            end
            P_RTWB: begin
                e.reg_write = 1'b1;
                e.reg_dst = 1'b1;
                e.done = 1'b1;
            end
            P_MA, P_AE: begin
                e.a = 2'd1;
                e.b = 2'd2;
            end
            P_MR: begin
                e.mem_read = 1'b1;
                e.iord = 1'b1;
            end
            P_MWB: begin
                e.reg_write = 1'b1;
                e.mem_to_reg = 1'b1;
                e.done = 1'b1;
            end
            P_MW: begin
                e.mem_write = 1'b1;
                e.iord = 1'b1;
                e.done = mr;
            end
            P_AW: begin
                e.reg_write = 1'b1;
                e.done = 1'b1;
            end
            P_BR: begin
                e.a = 2'd1;
                e.alu = 5'd1;
                e.pc_src = 2'd1;
                e.pc_write = (op == O_BEQ) ? z : ~z;
                e.done = 1'b1;
            end
            P_J: begin
                e.pc_src = 2'd2;
                e.pc_write = 1'b1;
                e.done = 1'b1;
            end
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    function automatic ov_t sample();
        ov_t o;
        o.pc_write = pc_write;
        o.pc_src = pc_src;
        o.iord = iord;
        o.mem_read = mem_read;
        o.mem_write = mem_write;
        o.ir_write = ir_write;
        o.reg_dst = reg_dst;
        o.mem_to_reg = mem_to_reg;
        o.reg_write = reg_write;
        o.a = alu_src_a;
        o.b = alu_src_b;
        o.alu = alu_ctrl;
        o.illegal = illegal;
        o.done = instr_done;
        return o;
    endfunction

    // Drives one instruction from FETCH to its last step. Entered and left
    // at a falling edge; a memory step waits stall_n not-ready cycles
    // (or random readiness when rnd is set) before mem_ready rises.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int stall_n,
                             input bit rnd);
        int idx;
        int waits;
        ph_t ph;
        bit memph;
        logic mr;
        logic ok;
        ov_t m;
        build_phases(op, fn);
        obs_q.delete();
        exp_q.delete();
        msk_q.delete();
        idx = 0;
        waits = 0;
        while (idx < ph_q.size() && obs_q.size() < 64) begin
            ph = ph_q[idx];
            memph = (ph == P_F) || (ph == P_MR) || (ph == P_MW);
            if (memph)
                mr = rnd ? ($urandom_range(0, 2) != 0) : (waits >= stall_n);
            else
                mr = 1'($urandom);
            opcode = op;
            funct = fn;
            zero = z;
            mem_ready = mr;
            #1;
            obs_q.push_back(sample());
            exp_q.push_back(exp_vec(ph, op, fn, mr, z));
            m = '1;
            if (ph == P_RT && ref_alu(fn, ok) == 5'd0 && !ok) m.alu = '0;
            msk_q.push_back(m);
            if (memph && !mr) waits++;
            else begin
                idx++;
                waits = 0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (mem_read !== 1'b1 || ir_write !== 1'b0 || pc_write !== 1'b0 ||
                reg_write !== 1'b0 || mem_write !== 1'b0 || iord !== 1'b0 ||
                alu_src_b !== 2'd1 || instr_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_state cyc%0d: got %h want mem_read=1 writes=0 b=1",
                         i, sample());
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ir_write !== 1'b1 || pc_write !== 1'b1 || mem_read !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: ir_write=%b pc_write=%b want 1 1",
                     ir_write, pc_write);
        end
        mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lw();
        run_instr(O_LW, 6'h00, 1'b0, 0, 1'b0);
        checks++;
        if (obs_q.size() != 5) begin
            errors++;
            $display("FAIL lw_latency: got %0d want 5", obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                errors++;
                $display("FAIL lw_cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q[4].reg_write !== 1'b1 || obs_q[4].mem_to_reg !== 1'b1) begin
            errors++;
            $display("FAIL lw_wb: reg_write=%b mem_to_reg=%b want 1 1",
                     obs_q[4].reg_write, obs_q[4].mem_to_reg);
        end
    endtask

    task automatic test_sw_stall();
        int wr;
        run_instr(O_SW, 6'h00, 1'b0, 3, 1'b0);
        wr = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            wr += int'(obs_q[i].mem_write);
            checks++;
            if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
                errors++;
                $display("FAIL sw_cyc%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (wr != 4) begin
            errors++;
            $display("FAIL sw_hold: mem_write cycles %0d want 4", wr);
        end
    endtask

    task automatic test_branch();
        run_instr(O_BEQ, 6'h00, 1'b1, 0, 1'b0);
        checks++;
        if (obs_q[2].pc_write !== 1'b1 || obs_q[2].pc_src !== 2'd1) begin
            errors++;
            $display("FAIL beq_taken: pc_write=%b pc_src=%0d want 1 1",
                     obs_q[2].pc_write, obs_q[2].pc_src);
        end
        run_instr(O_BNE, 6'h00, 1'b1, 0, 1'b0);
        checks++;
        if (obs_q[2].pc_write !== 1'b0 || obs_q[2].done !== 1'b1) begin
            errors++;
            $display("FAIL bne_not_taken: pc_write=%b done=%b want 0 1",
                     obs_q[2].pc_write, obs_q[2].done);
        end
    endtask

    task automatic test_rtype();
        int ill;
        int rw;
        run_instr(O_R, 6'b000010, 1'b0, 0, 1'b0);
        checks++;
        if (obs_q[2].a !== 2'd2 || obs_q[2].alu !== 5'd6) begin
            errors++;
            $display("FAIL srl_exec: a=%0d alu=%0d want 2 6",
                     obs_q[2].a, obs_q[2].alu);
        end
        run_instr(O_R, 6'b111111, 1'b0, 0, 1'b0);
        ill = 0;
        rw = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            ill += int'(obs_q[i].illegal);
            rw += int'(obs_q[i].reg_write);
        end
        checks++;
        if (ill != 1 || rw != 0) begin
            errors++;
            $display("FAIL bad_funct: illegal=%0d reg_write=%0d want 1 0", ill, rw);
        end
        run_instr(O_LW, 6'h00, 1'b0, 0, 1'b0);
        checks++;
        if (obs_q[0].mem_read !== 1'b1 || obs_q[0].ir_write !== 1'b1) begin
            errors++;
            $display("FAIL after_illegal: got %h want fetch", obs_q[0]);
        end
    endtask

    task automatic test_reset_midstall();
        mem_ready = 1'b1;
        opcode = O_SW;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL midstall_pre: mem_write=%b want 1", mem_write);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0 || instr_done !== 1'b0) begin
            errors++;
            $display("FAIL midstall_rst: mem_write=%b done=%b want 0 0",
                     mem_write, instr_done);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0 || mem_read !== 1'b1 || iord !== 1'b0 ||
            ir_write !== 1'b0) begin
            errors++;
            $display("FAIL midstall_after: got %h want fetch stalled", sample());
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [5:0] op, fn;
        logic [5:0] ops[7];
        logic [5:0] fns[7];
        int dn;
        int want_dn;
        ops = '{O_R, O_LW, O_SW, O_ADDI, O_BEQ, O_BNE, O_J};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                6'b101010, 6'b000000, 6'b000010};
        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 9) < 7) ? ops[$urandom_range(0, 6)]
                                            : 6'($urandom);
            fn = ($urandom_range(0, 3) != 0) ? fns[$urandom_range(0, 6)]
                                             : 6'($urandom);
            run_instr(op, fn, 1'($urandom), 0, 1'b1);
            dn = 0;
            for (int i = 0; i < obs_q.size(); i++) begin
                dn += int'(obs_q[i].done);
                checks++;
                if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i]) ||
                    (obs_q[i].mem_read & obs_q[i].mem_write) !== 1'b0 ||
                    (obs_q[i].reg_write & obs_q[i].pc_write) !== 1'b0) begin
                    errors++;
                    $display("FAIL rand op=%b fn=%b cyc%0d: got %h want %h",
                             op, fn, i, obs_q[i], exp_q[i]);
                end
            end
            want_dn = (ph_q[ph_q.size() - 1] == P_ILL) ? 0 : 1;
            checks++;
            if (dn != want_dn) begin
                errors++;
                $display("FAIL rand_done op=%b: got %0d want %0d", op, dn, want_dn);
            end
        end
    endtask

`ifdef MULTICYCLE_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_instr(O_LW, 6'h00, 1'b0, 0, 1'b0);
        run_instr(O_R, 6'b100000, 1'b0, 0, 1'b0);
        run_instr(O_J, 6'h00, 1'b0, 0, 1'b0);
        checks++;
        if (cycle_count !== 32'd12 || instr_count !== 32'd3) begin
            errors++;
            $display("FAIL perf: cycles=%0d instrs=%0d want 12 3",
                     cycle_count, instr_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_branch();
        test_rtype();
        test_reset_midstall();
        test_random();
`ifdef MULTICYCLE_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
